// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch PC sequencer: FSM states,
// next-PC source encoding and instruction alignment constants.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } seq_state_t;

  typedef enum logic [2:0] {
    SRC_SEQ   = 3'd0,
    SRC_HOLD  = 3'd1,
    SRC_BR    = 3'd2,
    SRC_TRAP  = 3'd3,
    SRC_MRET  = 3'd4,
    SRC_FAULT = 3'd5
  } pc_src_t;

  localparam int unsigned PC_STEP    = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  // Every source except sequential stepping and holding is a pipeline redirect.
  function automatic logic is_redirect(input pc_src_t src);
    return (src == SRC_BR) || (src == SRC_TRAP) ||
           (src == SRC_MRET) || (src == SRC_FAULT);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/address bundle between the PC sequencer and the execute stage,
// hazard unit, CSR file and instruction fetch.
interface pc_sequencer_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  stall_i;
  logic                  ex_redirect_i;
  logic [DATA_WIDTH-1:0] ex_target_i;
  logic [DATA_WIDTH-1:0] ex_pc_i;
  logic                  trap_i;
  logic [DATA_WIDTH-1:0] mtvec_i;
  logic                  mret_i;
  logic [DATA_WIDTH-1:0] mepc_i;
  logic                  halt_i;
  logic                  resume_i;
  logic [DATA_WIDTH-1:0] pc_f_o;
  logic                  fetch_valid_o;
  logic                  flush_d_o;
  logic                  flush_e_o;
  logic                  fault_o;
  logic [DATA_WIDTH-1:0] fault_pc_o;
  logic [DATA_WIDTH-1:0] fault_tval_o;
  logic [31:0]           redirect_cnt_o;

  // Driven by the surrounding pipeline.
  modport master (
    output stall_i, ex_redirect_i, ex_target_i, ex_pc_i, trap_i, mtvec_i,
           mret_i, mepc_i, halt_i, resume_i,
    input  pc_f_o, fetch_valid_o, flush_d_o, flush_e_o, fault_o,
           fault_pc_o, fault_tval_o, redirect_cnt_o
  );

  // Used by the sequencer itself.
  modport slave (
    input  stall_i, ex_redirect_i, ex_target_i, ex_pc_i, trap_i, mtvec_i,
           mret_i, mepc_i, halt_i, resume_i,
    output pc_f_o, fetch_valid_o, flush_d_o, flush_e_o, fault_o,
           fault_pc_o, fault_tval_o, redirect_cnt_o
  );
endinterface

// File: rtl/pc_sequencer_next_sel.sv
// Combinational next-PC priority selector: trap > mret > misaligned fault >
// branch > stall > PC+4. Pure logic, no state.
module pc_next_sel
  import pc_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic                  stall,
  input  logic                  redirect,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic                  trap,
  input  logic [DATA_WIDTH-1:0] mtvec,
  input  logic                  mret,
  input  logic [DATA_WIDTH-1:0] mepc,
  output pc_src_t               src,
  output logic [DATA_WIDTH-1:0] next_pc,
  output logic                  fault
);

  localparam logic [DATA_WIDTH-1:0] KEEP_MASK = ~DATA_WIDTH'(ALIGN_MASK);

  logic [DATA_WIDTH-1:0] mtvec_aligned;
  logic                  target_misaligned;

  assign mtvec_aligned     = mtvec & KEEP_MASK;
  assign target_misaligned = |(target[1:0] & ALIGN_MASK);

  always_comb begin
    src     = SRC_SEQ;
    next_pc = pc + DATA_WIDTH'(PC_STEP);
    fault   = 1'b0;
    if (trap) begin
      src     = SRC_TRAP;
      next_pc = mtvec_aligned;
    end else if (mret) begin
      src     = SRC_MRET;
      next_pc = mepc & KEEP_MASK;
    end else if (redirect && target_misaligned) begin
      // Misaligned targets vector to the trap handler instead of fetching.
      src     = SRC_FAULT;
      next_pc = mtvec_aligned;
      fault   = 1'b1;
    end else if (redirect) begin
      src     = SRC_BR;
      next_pc = target;
    end else if (stall) begin
      src     = SRC_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC owner: boot hold-off, RUN/HALT sequencing, redirect flushes,
// misaligned-target fault capture and a wrapping redirect counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    BOOT_CYCLES  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.slave   bus
);

  seq_state_t            state;
  seq_state_t            state_nxt;
  logic [31:0]           boot_cnt;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] pc_nxt;
  logic                  take_redirect;
  logic                  fault_set;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] fault_pc_q;
  logic [DATA_WIDTH-1:0] fault_tval_q;
  logic [31:0]           redirect_cnt;

  pc_src_t               sel_src;
  logic [DATA_WIDTH-1:0] sel_pc;
  logic                  sel_fault;

  pc_next_sel #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_next_sel (
    .pc       (pc),
    .stall    (bus.stall_i),
    .redirect (bus.ex_redirect_i),
    .target   (bus.ex_target_i),
    .trap     (bus.trap_i),
    .mtvec    (bus.mtvec_i),
    .mret     (bus.mret_i),
    .mepc     (bus.mepc_i),
    .src      (sel_src),
    .next_pc  (sel_pc),
    .fault    (sel_fault)
  );

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    take_redirect = 1'b0;
    fault_set     = 1'b0;
    case (state)
      BOOT: begin
        if (boot_cnt == 32'(BOOT_CYCLES - 1)) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        // A redirect in the halt-request cycle still lands before halting.
        pc_nxt        = sel_pc;
        take_redirect = is_redirect(sel_src);
        fault_set     = sel_fault;
        if (bus.halt_i) begin
          state_nxt = HALT;
        end
      end
      HALT: begin
        if (bus.resume_i) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      boot_cnt     <= '0;
      pc           <= RESET_VECTOR;
      fault_q      <= 1'b0;
      fault_pc_q   <= '0;
      fault_tval_q <= '0;
      redirect_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      fault_q <= fault_set;
      if (state == BOOT) begin
        boot_cnt <= boot_cnt + 32'd1;
      end
      if (fault_set) begin
        fault_pc_q   <= bus.ex_pc_i;
        fault_tval_q <= bus.ex_target_i;
      end
      if (take_redirect) begin
        redirect_cnt <= redirect_cnt + 32'd1;
      end
    end
  end

  assign bus.pc_f_o         = pc;
  assign bus.fetch_valid_o  = (state == RUN);
  assign bus.flush_d_o      = take_redirect;
  assign bus.flush_e_o      = take_redirect;
  assign bus.fault_o        = fault_q;
  assign bus.fault_pc_o     = fault_pc_q;
  assign bus.fault_tval_o   = fault_tval_q;
  assign bus.redirect_cnt_o = redirect_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand-written
// wrap/reset sequences and a randomized run against a behavioural model.
module tb_pc_sequencer;

  localparam int BOOT = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  pc_sequencer_if #(.DATA_WIDTH(32)) bus ();

  pc_sequencer #(
    .DATA_WIDTH   (32),
    .RESET_VECTOR (32'h0000_0000),
    .BOOT_CYCLES  (BOOT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        st, rd;
    logic [31:0] tg, ep;
    logic        tr;
    logic [31:0] mt;
    logic        mr;
    logic [31:0] me;
    logic        hl, rs;
    logic [31:0] e_pc;
    logic        e_fv, e_fl, e_ft;
    logic [31:0] e_cnt, e_fpc, e_ftv;
  } vec_t;

  function automatic vec_t mk(input logic st, rd, input logic [31:0] tg, ep,
                              input logic tr, input logic [31:0] mt,
                              input logic mr, input logic [31:0] me,
                              input logic hl, rs, input logic [31:0] pc,
                              input logic fv, fl, ft,
                              input logic [31:0] cnt, fpc, ftv);
    vec_t v;
    v.st = st; v.rd = rd; v.tg = tg; v.ep = ep; v.tr = tr; v.mt = mt;
    v.mr = mr; v.me = me; v.hl = hl; v.rs = rs;
    v.e_pc = pc; v.e_fv = fv; v.e_fl = fl; v.e_ft = ft;
    v.e_cnt = cnt; v.e_fpc = fpc; v.e_ftv = ftv;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, rd, input logic [31:0] tg, ep,
                       input logic tr, input logic [31:0] mt,
                       input logic mr, input logic [31:0] me,
                       input logic hl, rs);
    bus.stall_i = st; bus.ex_redirect_i = rd; bus.ex_target_i = tg;
    bus.ex_pc_i = ep; bus.trap_i = tr; bus.mtvec_i = mt; bus.mret_i = mr;
    bus.mepc_i = me; bus.halt_i = hl; bus.resume_i = rs;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc"},    bus.pc_f_o, 32'h0);
    check({tag, " fv"},    32'(bus.fetch_valid_o), 0);
    check({tag, " fl_d"},  32'(bus.flush_d_o), 0);
    check({tag, " fl_e"},  32'(bus.flush_e_o), 0);
    check({tag, " fault"}, 32'(bus.fault_o), 0);
    check({tag, " fpc"},   bus.fault_pc_o, 32'h0);
    check({tag, " ftval"}, bus.fault_tval_o, 32'h0);
    check({tag, " cnt"},   bus.redirect_cnt_o, 32'h0);
  endtask

  vec_t vecs[$];

  // Behavioural model state
  int          m_boot_left;
  bit          m_halted;
  logic [31:0] m_pc, m_cnt, m_fpc, m_ftv;
  bit          m_fault;

  task automatic model_reset();
    m_boot_left = BOOT; m_halted = 0; m_pc = 0; m_cnt = 0;
    m_fpc = 0; m_ftv = 0; m_fault = 0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    idle();

    // Boot phase with redirects/traps/halts that must be ignored, then the plan.
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h0,   0,0,0, 0,0,0));
    vecs.push_back(mk(1,1,32'h200,0, 0,0, 0,0, 0,0, 32'h0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 1,32'h500, 1,32'h80, 1,0, 32'h0, 0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h0,   0,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h0,   1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h4,   1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h8,   1,0,0, 0,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'hC,   1,0,0, 0,0,0));
    vecs.push_back(mk(1,1,32'h200,0, 0,0, 0,0, 0,0, 32'h10, 1,1,0, 0,0,0));
    vecs.push_back(mk(0,1,32'h102,32'h40, 0,32'h1003, 0,0, 0,0, 32'h200, 1,1,0, 1,0,0));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h1000, 1,0,1, 2,32'h40,32'h102));
    vecs.push_back(mk(0,1,32'h301,32'h44, 1,32'h500, 1,32'h80, 0,0, 32'h1004, 1,1,0, 2,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 1,32'h83, 0,0, 32'h500, 1,1,0, 3,32'h40,32'h102));
    vecs.push_back(mk(1,0,0,0, 0,0, 0,0, 0,0, 32'h80,  1,0,0, 4,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h80,  1,0,0, 4,32'h40,32'h102));
    vecs.push_back(mk(0,1,32'h20,0, 0,0, 0,0, 0,0, 32'h84, 1,1,0, 4,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 1,0, 32'h20,  1,0,0, 5,32'h40,32'h102));
    vecs.push_back(mk(1,1,32'h300,0, 1,32'h600, 1,32'h90, 0,0, 32'h24, 0,0,0, 5,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 1,1, 32'h24,  0,0,0, 5,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h24,  1,0,0, 5,32'h40,32'h102));
    vecs.push_back(mk(0,1,32'h400,0, 0,0, 0,0, 1,0, 32'h28, 1,1,0, 5,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,1, 32'h400, 0,0,0, 6,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h400, 1,0,0, 6,32'h40,32'h102));
    vecs.push_back(mk(0,0,0,0, 0,0, 0,0, 0,0, 32'h404, 1,0,0, 6,32'h40,32'h102));

    repeat (2) @(negedge clk);
    #1 check_reset_values("reset");

    foreach (vecs[i]) begin
      @(negedge clk);
      if (i == 0) rst_n = 1'b1;
      drive(vecs[i].st, vecs[i].rd, vecs[i].tg, vecs[i].ep, vecs[i].tr,
            vecs[i].mt, vecs[i].mr, vecs[i].me, vecs[i].hl, vecs[i].rs);
      #1;
      check($sformatf("v%0d pc", i),    bus.pc_f_o, vecs[i].e_pc);
      check($sformatf("v%0d fv", i),    32'(bus.fetch_valid_o), 32'(vecs[i].e_fv));
      check($sformatf("v%0d fl_d", i),  32'(bus.flush_d_o), 32'(vecs[i].e_fl));
      check($sformatf("v%0d fl_e", i),  32'(bus.flush_e_o), 32'(vecs[i].e_fl));
      check($sformatf("v%0d fault", i), 32'(bus.fault_o), 32'(vecs[i].e_ft));
      check($sformatf("v%0d cnt", i),   bus.redirect_cnt_o, vecs[i].e_cnt);
      check($sformatf("v%0d fpc", i),   bus.fault_pc_o, vecs[i].e_fpc);
      check($sformatf("v%0d ftval", i), bus.fault_tval_o, vecs[i].e_ftv);
    end

    // PC wrap at the top of the address space.
    @(negedge clk);
    drive(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0);
    #1 check("wrap redirect pc", bus.pc_f_o, 32'h408);
    @(negedge clk);
    idle();
    #1 check("wrap top pc", bus.pc_f_o, 32'hFFFF_FFFC);
    @(negedge clk);
    #1 check("wrap zero pc", bus.pc_f_o, 32'h0);
    check("wrap cnt", bus.redirect_cnt_o, 32'd7);

    // Reset mid-run with a redirect pending: everything clears at once.
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1, 32'h700, 0, 0, 0, 0, 0, 0, 0);
    #1 check_reset_values("midrst");
    @(negedge clk);
    idle();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) rst_n = 1'b1;
      #1;
      check($sformatf("reboot c%0d fv", c), 32'(bus.fetch_valid_o), (c >= BOOT) ? 1 : 0);
      check($sformatf("reboot c%0d pc", c), bus.pc_f_o, (c == BOOT + 1) ? 32'h4 : 32'h0);
    end

    // Randomized run against the behavioural model, with occasional resets.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      logic        st, rd, tr, mr, hl, rs, do_rst;
      logic [31:0] tg, ep, mt, me;
      bit          running, red, fault_n;
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
        model_reset();
      end
      do_rst = ($urandom_range(0, 499) == 0);
      st = ($urandom_range(0, 3) == 0);
      rd = ($urandom_range(0, 3) == 0);
      tg = {$urandom} & 32'hFFFF_FFF0;
      if ($urandom_range(0, 3) == 0) tg = tg | 32'($urandom_range(1, 3));
      else if ($urandom_range(0, 1) == 0) tg = tg | 32'h4;
      ep = $urandom;
      tr = ($urandom_range(0, 15) == 0);
      mt = $urandom;
      mr = ($urandom_range(0, 15) == 0);
      me = $urandom;
      hl = ($urandom_range(0, 19) == 0);
      rs = ($urandom_range(0, 3) == 0);
      drive(st, rd, tg, ep, tr, mt, mr, me, hl, rs);
      if (do_rst) begin
        rst_n = 1'b0;
        #1 check_reset_values("rnd rst");
        model_reset();
        continue;
      end
      #1;
      running = (m_boot_left == 0) && !m_halted;
      red     = running && (tr || mr || rd);
      check("rnd pc",    bus.pc_f_o, m_pc);
      check("rnd fv",    32'(bus.fetch_valid_o), 32'(running));
      check("rnd fl_d",  32'(bus.flush_d_o), 32'(red));
      check("rnd fl_e",  32'(bus.flush_e_o), 32'(red));
      check("rnd fault", 32'(bus.fault_o), 32'(m_fault));
      check("rnd fpc",   bus.fault_pc_o, m_fpc);
      check("rnd ftval", bus.fault_tval_o, m_ftv);
      check("rnd cnt",   bus.redirect_cnt_o, m_cnt);
      fault_n = 0;
      if (m_boot_left > 0) begin
        m_boot_left--;
      end else if (m_halted) begin
        if (rs) m_halted = 0;
      end else begin
        if (tr)                 m_pc = mt & ~32'h3;
        else if (mr)            m_pc = me & ~32'h3;
        else if (rd && (tg % 4 != 0)) begin
          m_pc = mt & ~32'h3;
          fault_n = 1;
          m_fpc = ep;
          m_ftv = tg;
        end
        else if (rd)            m_pc = tg;
        else if (!st)           m_pc = m_pc + 32'd4;
        if (red) m_cnt = m_cnt + 1;
        if (hl)  m_halted = 1;
      end
      m_fault = fault_n;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Owns the fetch PC register and chooses the next PC each cycle. Sources are sequential PC+4, the execute-stage branch/jump target (the PC-target adder result), trap vector entry and mret return. Sits between the execute-stage target datapath, the hazard unit and instruction fetch. Also generates flushes, detects misaligned-target faults, sequences boot and halt/resume, and counts redirects.

Parameters:
DATA_WIDTH, 32, width of PC and all address ports
RESET_VECTOR, 32'h0000_0000, PC value loaded at reset
BOOT_CYCLES, 4, cycles fetch is held off after reset release (must be >= 1)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall_i  in  1  hazard unit: hold PC
ex_redirect_i  in  1  execute stage: taken branch, JAL or JALR
ex_target_i  in  DATA_WIDTH  redirect target from the PC-target datapath
ex_pc_i  in  DATA_WIDTH  PC of the redirecting instruction
trap_i  in  1  take trap (ecall/illegal etc.)
mtvec_i  in  DATA_WIDTH  trap vector base
mret_i  in  1  return from trap
mepc_i  in  DATA_WIDTH  mret return address
halt_i  in  1  request halt (debug/ebreak)
resume_i  in  1  leave halt
pc_f_o  out  DATA_WIDTH  current fetch PC
fetch_valid_o  out  1  pc_f_o is a valid fetch request
flush_d_o  out  1  flush decode pipeline register (combinational)
flush_e_o  out  1  flush execute pipeline register (combinational)
fault_o  out  1  one-cycle misaligned-target fault pulse (registered)
fault_pc_o  out  DATA_WIDTH  ex_pc_i of the faulting instruction
fault_tval_o  out  DATA_WIDTH  faulting target address
redirect_cnt_o  out  32  accepted redirects, wrapping

Behaviour:
- Reset (async, rst_n=0) values:
  - pc_f_o=RESET_VECTOR, state=BOOT, boot counter=0.
  - fetch_valid_o=0, flush_d_o=0, flush_e_o=0, fault_o=0.
  - fault_pc_o=0, fault_tval_o=0, redirect_cnt_o=0.
- Reset mid-operation aborts everything and restores these values.
- States: BOOT, RUN, HALT.
- BOOT:
  - fetch_valid_o=0, PC held, all redirect/stall/halt inputs ignored, flushes 0.
  - Counter increments each cycle. At count BOOT_CYCLES-1 go to RUN.
  - The first valid fetch therefore occurs exactly BOOT_CYCLES cycles after rst_n rises.
- RUN: fetch_valid_o=1. Next PC is chosen by strict priority:
  1. trap_i -> mtvec_i with bits [1:0] forced to 0.
  2. mret_i -> mepc_i with bits [1:0] forced to 0.
  3. ex_redirect_i with ex_target_i[1:0]!=0 (misaligned fault):
     - PC -> aligned mtvec.
     - Next cycle: fault_o=1 for one cycle, fault_pc_o=ex_pc_i, fault_tval_o=ex_target_i.
     - fault_pc_o and fault_tval_o hold until the next fault.
  4. ex_redirect_i, target aligned -> PC = ex_target_i.
  5. stall_i -> PC held.
  6. Otherwise -> PC+4, wrapping modulo 2^DATA_WIDTH.
- Any accepted redirect (priorities 1-4):
  - flush_d_o=1 and flush_e_o=1 in the same cycle.
  - redirect_cnt_o increments by 1 (wraps at 2^32).
  - A redirect overrides stall_i.
- Halt sequencing:
  - halt_i in RUN moves to HALT next cycle. Any redirect accepted in that same cycle still updates the PC first.
  - HALT: fetch_valid_o=0, PC held. trap_i, mret_i, ex_redirect_i and stall_i are ignored; flushes are 0.
  - resume_i in HALT moves to RUN next cycle; fetch resumes at the held PC.
  - halt_i and resume_i together in HALT: resume wins.
- Simultaneous events:
  - trap_i with ex_redirect_i: trap wins, and no fault is raised even if the target is misaligned.
  - trap_i with mret_i: trap wins.
- Latency: the PC register updates on the edge after the decision; flushes are combinational.

Decomposition:
- Shared core package (pc_seq_pkg):
  - state enum {BOOT, RUN, HALT}.
  - PC_STEP=4.
  - next-PC-source enum {SRC_SEQ, SRC_HOLD, SRC_BR, SRC_TRAP, SRC_MRET, SRC_FAULT}.
  - ALIGN_MASK constant.
- One sub-module, pc_next_sel: the combinational priority selector returning source enum, next PC and the fault flag.
- The top module holds the FSM, registers and counters.

Test Plan:
- Reset, BOOT_CYCLES=4: rst_n rises; fetch_valid_o stays 0 for cycles 0-3. Cycle 4: fetch_valid_o=1, pc_f_o=0x0; then 0x4, 0x8.
- Branch over stall: at PC 0x10 drive ex_redirect_i=1, ex_target_i=0x200 and stall_i=1 together. Expect flush_d_o/flush_e_o=1 that cycle, next pc_f_o=0x200, redirect_cnt_o=1.
- Misaligned JALR-style target: ex_target_i=0x102, ex_pc_i=0x40, mtvec_i=0x1003. Expect next pc_f_o=0x1000, fault_o pulse for one cycle, fault_pc_o=0x40, fault_tval_o=0x102.
- Priority: trap_i, mret_i (mepc_i=0x80) and ex_redirect_i (target 0x300) in one cycle with mtvec_i=0x500. Expect pc_f_o=0x500, no fault_o, redirect_cnt_o increments by 1.
- Halt/resume: halt_i at PC 0x20 with no redirect. Expect fetch_valid_o=0 and PC held at 0x24. Drive ex_redirect_i in HALT: ignored, no flush. resume_i: fetch resumes at 0x24, then 0x28.
- Wrap and reset: PC at 0xFFFF_FFFC steps to 0x0. Then assert rst_n=0 mid-run: outputs return to reset values immediately, and the BOOT sequence repeats.
